// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller for the 16-bit ID/EX/MEM/WB core.
// Tracks the destination of every in-flight instruction (EX, MEM, WB slots) and
// the multi-cycle mul/div unit that writes R0. Resolves per-port forward selects
// (00 register file, 01 WB write data, 10 R0 mul/div result) and the ID stall.
// Optional feature macro: HAZARD_FWD_WB_EN -- when defined, a WB-slot match is
// forwarded with select 01; when undefined it stalls one cycle and the operand
// is read from the register file afterwards (select 01 is never driven).
module hazard_ctrl #(
  parameter int REG_NUM_WIDTH = 4,
  parameter int MD_LATENCY    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REG_NUM_WIDTH-1:0] id_rn_a,
  input  logic [REG_NUM_WIDTH-1:0] id_rn_b,
  input  logic                     id_use_a,
  input  logic                     id_use_b,
  input  logic                     id_wr_en,
  input  logic [REG_NUM_WIDTH-1:0] id_rd,
  input  logic                     id_mdiv,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b,
  output logic                     stall,
  output logic                     issue,
  output logic                     wb_wr_en,
  output logic [REG_NUM_WIDTH-1:0] wb_rd,
  output logic                     md_start,
  output logic                     md_busy
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

  // Last counter value reached while BUSY; the following cycle is DONE.
  localparam logic [3:0] MD_LAST = 4'(MD_LATENCY - 1);
  localparam logic [REG_NUM_WIDTH-1:0] REG_ZERO = {REG_NUM_WIDTH{1'b0}};

  // Pipeline slots: valid, writes-register flag, destination.
  logic                     ex_valid_r,  mem_valid_r,  wb_valid_r;
  logic                     ex_wr_r,     mem_wr_r,     wb_wr_r;
  logic [REG_NUM_WIDTH-1:0] ex_rd_r,     mem_rd_r,     wb_rd_r;

  // Mul/div sequencer.
  md_state_t  md_state_r, md_state_s;
  logic [3:0] md_cnt_r,   md_cnt_s;
  logic       md_start_r, md_busy_r;

  // Hazard resolution intermediates.
  logic       near_a_s, near_b_s, wb_a_s, wb_b_s;
  logic [2:0] res_a_s, res_b_s;
  logic       md_active_s, r0_writer_s, struct_haz_s, stall_s, issue_s, ex_wr_s;

  // Resolve one read port. Returns {hazard, fwd_select}; first match wins.
  // A pending R0 result from the mul/div unit outranks any slot match on R0.
  function automatic logic [2:0] resolve_port(
    input logic use_x,
    input logic rn_zero,
    input logic md_done,
    input logic md_busy_only,
    input logic near_hit,
    input logic wb_hit
  );
    logic [2:0] res;
    if (!use_x) begin
      res = 3'b000;
    end else if (rn_zero && md_done) begin
      res = 3'b010;
    end else if (rn_zero && md_busy_only) begin
      res = 3'b100;
    end else if (near_hit) begin
      res = 3'b100;
    end else if (wb_hit) begin
`ifdef HAZARD_FWD_WB_EN
      res = 3'b001;
`else
      res = 3'b100;
`endif
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  // Per-port source matching against the in-flight writers.
  always_comb begin
    near_a_s = (ex_valid_r  & ex_wr_r  & (ex_rd_r  == id_rn_a)) |
               (mem_valid_r & mem_wr_r & (mem_rd_r == id_rn_a));
    near_b_s = (ex_valid_r  & ex_wr_r  & (ex_rd_r  == id_rn_b)) |
               (mem_valid_r & mem_wr_r & (mem_rd_r == id_rn_b));
    wb_a_s   = wb_valid_r & wb_wr_r & (wb_rd_r == id_rn_a);
    wb_b_s   = wb_valid_r & wb_wr_r & (wb_rd_r == id_rn_b);
  end

  // Port resolution, structural hazards, stall and forward selects.
  always_comb begin
    md_active_s = (md_state_r != MD_IDLE);
    r0_writer_s = (ex_valid_r  & ex_wr_r  & (ex_rd_r  == REG_ZERO)) |
                  (mem_valid_r & mem_wr_r & (mem_rd_r == REG_ZERO)) |
                  (wb_valid_r  & wb_wr_r  & (wb_rd_r  == REG_ZERO));
    res_a_s = resolve_port(id_valid & id_use_a, (id_rn_a == REG_ZERO),
                           (md_state_r == MD_DONE), (md_state_r == MD_BUSY),
                           near_a_s, wb_a_s);
    res_b_s = resolve_port(id_valid & id_use_b, (id_rn_b == REG_ZERO),
                           (md_state_r == MD_DONE), (md_state_r == MD_BUSY),
                           near_b_s, wb_b_s);
    // Only one R0 producer may be in flight at a time.
    struct_haz_s = id_valid & ((id_mdiv & md_active_s) |
                               (id_mdiv & r0_writer_s) |
                               (id_wr_en & ~id_mdiv & (id_rd == REG_ZERO) & md_active_s));
    stall_s = res_a_s[2] | res_b_s[2] | struct_haz_s;
    issue_s = id_valid & ~stall_s;
    // A mul/div result reaches R0 through the unit, never through WB.
    ex_wr_s = issue_s & id_wr_en & ~id_mdiv;
    if (stall_s) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end else begin
      fwd_a = res_a_s[1:0];
      fwd_b = res_b_s[1:0];
    end
  end

  // Mul/div next state: IDLE -> BUSY on issue, count to MD_LATENCY-1, one DONE cycle.
  always_comb begin
    md_state_s = md_state_r;
    md_cnt_s   = md_cnt_r;
    case (md_state_r)
      MD_IDLE: begin
        if (issue_s && id_mdiv) begin
          md_state_s = MD_BUSY;
          md_cnt_s   = 4'd0;
        end else begin
          md_state_s = MD_IDLE;
          md_cnt_s   = 4'd0;
        end
      end
      MD_BUSY: begin
        md_cnt_s = md_cnt_r + 4'd1;
        if ((md_cnt_r + 4'd1) == MD_LAST) begin
          md_state_s = MD_DONE;
        end else begin
          md_state_s = MD_BUSY;
        end
      end
      MD_DONE: begin
        md_state_s = MD_IDLE;
        md_cnt_s   = 4'd0;
      end
      default: begin
        md_state_s = MD_IDLE;
        md_cnt_s   = 4'd0;
      end
    endcase
  end

  // Mul/div state, counter and registered start/busy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state_r <= MD_IDLE;
      md_cnt_r   <= 4'd0;
      md_start_r <= 1'b0;
      md_busy_r  <= 1'b0;
    end else begin
      md_state_r <= md_state_s;
      md_cnt_r   <= md_cnt_s;
      md_start_r <= (md_state_r == MD_IDLE) && (md_state_s == MD_BUSY);
      md_busy_r  <= (md_state_s != MD_IDLE);
    end
  end

  // Slot shift: EX takes the issued instruction or a bubble; slots never hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r  <= 1'b0;
      ex_wr_r     <= 1'b0;
      ex_rd_r     <= REG_ZERO;
      mem_valid_r <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_rd_r    <= REG_ZERO;
      wb_valid_r  <= 1'b0;
      wb_wr_r     <= 1'b0;
      wb_rd_r     <= REG_ZERO;
    end else begin
      ex_valid_r  <= issue_s;
      ex_wr_r     <= ex_wr_s;
      ex_rd_r     <= ex_wr_s ? id_rd : REG_ZERO;
      mem_valid_r <= ex_valid_r;
      mem_wr_r    <= ex_wr_r;
      mem_rd_r    <= ex_rd_r;
      wb_valid_r  <= mem_valid_r;
      wb_wr_r     <= mem_wr_r;
      wb_rd_r     <= mem_rd_r;
    end
  end

  assign stall    = stall_s;
  assign issue    = issue_s;
  assign wb_wr_en = wb_valid_r & wb_wr_r;
  assign wb_rd    = wb_rd_r;
  assign md_start = md_start_r;
  assign md_busy  = md_busy_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle table, hand-written multi-cycle
// sequences, and randomized traffic, all also compared every cycle against a
// reference model based on instruction ages and mul/div issue time.
module tb_hazard_ctrl;
  localparam int MD_L = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_use_a, id_use_b, id_wr_en, id_mdiv;
  logic [3:0] id_rn_a, id_rn_b, id_rd;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, issue, wb_wr_en, md_start, md_busy;
  logic [3:0] wb_rd;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_NUM_WIDTH(4), .MD_LATENCY(MD_L)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rn_a(id_rn_a), .id_rn_b(id_rn_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .id_wr_en(id_wr_en), .id_rd(id_rd), .id_mdiv(id_mdiv),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .issue(issue),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .md_start(md_start), .md_busy(md_busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: list of issued instructions with their issue cycle.
  typedef struct { int c; bit wr; logic [3:0] rd; } inst_t;
  inst_t hist[$];
  int    cyc = 0;
  int    md_t = -100;
  bit    e_issue = 1'b0;
  bit    e_stall = 1'b0;

  typedef struct {
    logic v, ua; logic [3:0] ra; logic ub; logic [3:0] rb;
    logic wr; logic [3:0] rd; logic md;
    logic [1:0] fa, fb; logic st, is;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Youngest in-flight writer of r, by age (1=EX, 2=MEM, 3=WB), or 0 if none.
  function automatic int writer_age(input logic [3:0] r);
    int best = 0;
    foreach (hist[i]) begin
      int a = cyc - hist[i].c;
      if (hist[i].wr && hist[i].rd == r && a >= 1 && a <= 3 && (best == 0 || a < best))
        best = a;
    end
    return best;
  endfunction

  // Expected {hazard, select} for one read port.
  function automatic logic [2:0] port_m(input logic u, input logic [3:0] rn,
                                        input bit busy, input bit done);
    int a;
    if (!u) return 3'b000;
    if (rn == 4'd0 && done) return 3'b010;
    if (rn == 4'd0 && busy) return 3'b100;
    a = writer_age(rn);
    if (a == 1 || a == 2) return 3'b100;
`ifdef HAZARD_FWD_WB_EN
    if (a == 3) return 3'b001;
`else
    if (a == 3) return 3'b100;
`endif
    return 3'b000;
  endfunction

  task automatic set_in(input logic v, input logic ua, input logic [3:0] ra,
                        input logic ub, input logic [3:0] rb, input logic wr,
                        input logic [3:0] rd, input logic md);
    id_valid = v; id_use_a = ua; id_rn_a = ra; id_use_b = ub; id_rn_b = rb;
    id_wr_en = wr; id_rd = rd; id_mdiv = md;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic eval();
    int d;
    bit busy, done, st, wbe;
    logic [2:0] pa, pb;
    logic [3:0] wbr;
    #1;
    d = cyc - md_t;
    busy = (d >= 1 && d <= MD_L - 1);
    done = (d == MD_L);
    pa = port_m(id_valid & id_use_a, id_rn_a, busy, done);
    pb = port_m(id_valid & id_use_b, id_rn_b, busy, done);
    st = id_valid && ((id_mdiv && (busy || done)) || (id_mdiv && writer_age(4'd0) != 0) ||
                      (id_wr_en && !id_mdiv && id_rd == 4'd0 && (busy || done)));
    st = st || pa[2] || pb[2];
    e_stall = st;
    e_issue = id_valid && !st;
    wbe = 1'b0; wbr = 4'd0;
    foreach (hist[i]) if (hist[i].c == cyc - 3 && hist[i].wr) begin wbe = 1'b1; wbr = hist[i].rd; end
    chk("m_stall", {7'd0, stall}, {7'd0, st});
    chk("m_issue", {7'd0, issue}, {7'd0, e_issue});
    chk("m_fwd_a", {6'd0, fwd_a}, st ? 8'd0 : {6'd0, pa[1:0]});
    chk("m_fwd_b", {6'd0, fwd_b}, st ? 8'd0 : {6'd0, pb[1:0]});
    chk("m_wb_wr_en", {7'd0, wb_wr_en}, {7'd0, wbe});
    if (wbe) chk("m_wb_rd", {4'd0, wb_rd}, {4'd0, wbr});
    chk("m_md_start", {7'd0, md_start}, {7'd0, (d == 1)});
    chk("m_md_busy", {7'd0, md_busy}, {7'd0, (busy || done)});
  endtask

  // Clock edge; the model records whatever issued in the cycle just ended.
  task automatic tick();
    @(posedge clk);
    if (rst_n && e_issue) begin
      hist.push_back('{c: cyc, wr: (id_wr_en && !id_mdiv), rd: id_rd});
      if (id_mdiv) md_t = cyc;
    end
    cyc++;
    while (hist.size() > 0 && cyc - hist[0].c > 3) void'(hist.pop_front());
    #1;
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    hist.delete();
    md_t = -100;
  endtask

  task automatic step_idle(input int n);
    for (int i = 0; i < n; i++) begin idle(); eval(); tick(); end
  endtask

  function automatic vec_t mk(input logic v, input logic ua, input logic [3:0] ra,
                              input logic ub, input logic [3:0] rb, input logic wr,
                              input logic [3:0] rd, input logic md, input logic [1:0] fa,
                              input logic [1:0] fb, input logic st, input logic is);
    vec_t x;
    x.v = v; x.ua = ua; x.ra = ra; x.ub = ub; x.rb = rb; x.wr = wr; x.rd = rd; x.md = md;
    x.fa = fa; x.fb = fb; x.st = st; x.is = is;
    return x;
  endfunction

  initial begin
    // Reset state.
    idle();
    reset_now();
    eval();
    chk("rst_wb_wr_en", {7'd0, wb_wr_en}, 8'd0);
    chk("rst_wb_rd", {4'd0, wb_rd}, 8'd0);
    chk("rst_md_busy", {7'd0, md_busy}, 8'd0);
    chk("rst_md_start", {7'd0, md_start}, 8'd0);
    chk("rst_stall", {7'd0, stall}, 8'd0);
    chk("rst_fwd", {4'd0, fwd_a, fwd_b}, 8'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Cycle table: back-to-back dependency, unused port, WB-slot match, R0 idle.
    vecs.push_back(mk(1, 0, 4'd0, 0, 4'd0, 1, 4'd3, 0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk(1, 1, 4'd3, 0, 4'd0, 0, 4'd0, 0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(1, 1, 4'd3, 0, 4'd0, 0, 4'd0, 0, 2'b00, 2'b00, 1, 0));
`ifdef HAZARD_FWD_WB_EN
    vecs.push_back(mk(1, 1, 4'd3, 0, 4'd0, 0, 4'd0, 0, 2'b01, 2'b00, 0, 1));
`else
    vecs.push_back(mk(1, 1, 4'd3, 0, 4'd0, 0, 4'd0, 0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(1, 1, 4'd3, 0, 4'd0, 0, 4'd0, 0, 2'b00, 2'b00, 0, 1));
`endif
    vecs.push_back(mk(1, 0, 4'd0, 0, 4'd0, 1, 4'd7, 0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk(1, 0, 4'd7, 0, 4'd0, 0, 4'd0, 0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk(1, 0, 4'd0, 1, 4'd7, 0, 4'd0, 0, 2'b00, 2'b00, 1, 0));
`ifdef HAZARD_FWD_WB_EN
    vecs.push_back(mk(1, 0, 4'd0, 1, 4'd7, 0, 4'd0, 0, 2'b00, 2'b01, 0, 1));
`else
    vecs.push_back(mk(1, 0, 4'd0, 1, 4'd7, 0, 4'd0, 0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(1, 0, 4'd0, 1, 4'd7, 0, 4'd0, 0, 2'b00, 2'b00, 0, 1));
`endif
    vecs.push_back(mk(1, 1, 4'd0, 1, 4'd0, 0, 4'd0, 0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk(0, 1, 4'd7, 1, 4'd3, 1, 4'd0, 0, 2'b00, 2'b00, 0, 0));
    foreach (vecs[i]) begin
      set_in(vecs[i].v, vecs[i].ua, vecs[i].ra, vecs[i].ub, vecs[i].rb,
             vecs[i].wr, vecs[i].rd, vecs[i].md);
      eval();
      chk($sformatf("vec%0d_fwd_a", i), {6'd0, fwd_a}, {6'd0, vecs[i].fa});
      chk($sformatf("vec%0d_fwd_b", i), {6'd0, fwd_b}, {6'd0, vecs[i].fb});
      chk($sformatf("vec%0d_stall", i), {7'd0, stall}, {7'd0, vecs[i].st});
      chk($sformatf("vec%0d_issue", i), {7'd0, issue}, {7'd0, vecs[i].is});
      tick();
    end
    step_idle(4);

    // Mul/div with an R0 reader waiting on port B.
    set_in(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1); eval();
    chk("md_issue", {7'd0, issue}, 8'd1);
    tick();
    for (int k = 1; k <= 3; k++) begin
      set_in(1, 0, 4'd0, 1, 4'd0, 0, 4'd0, 0); eval();
      chk($sformatf("md_rd_stall_t%0d", k), {7'd0, stall}, 8'd1);
      chk($sformatf("md_start_t%0d", k), {7'd0, md_start}, (k == 1) ? 8'd1 : 8'd0);
      tick();
    end
    set_in(1, 0, 4'd0, 1, 4'd0, 0, 4'd0, 0); eval();
    chk("md_done_fwd_b", {6'd0, fwd_b}, 8'd2);
    chk("md_done_issue", {7'd0, issue}, 8'd1);
    chk("md_done_busy", {7'd0, md_busy}, 8'd1);
    tick();
    idle(); eval();
    chk("md_idle_busy", {7'd0, md_busy}, 8'd0);
    tick();
    step_idle(2);

    // Dual port: A reads R5 in WB while B reads R0 in DONE.
    set_in(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1); eval(); tick();
    set_in(1, 0, 4'd0, 0, 4'd0, 1, 4'd5, 0); eval();
    chk("dual_wr5_issue", {7'd0, issue}, 8'd1);
    tick();
    step_idle(2);
    set_in(1, 1, 4'd5, 1, 4'd0, 0, 4'd0, 0); eval();
`ifdef HAZARD_FWD_WB_EN
    chk("dual_fwd_a", {6'd0, fwd_a}, 8'd1);
    chk("dual_fwd_b", {6'd0, fwd_b}, 8'd2);
    chk("dual_stall", {7'd0, stall}, 8'd0);
`else
    chk("dual_stall", {7'd0, stall}, 8'd1);
    chk("dual_fwd_ab", {4'd0, fwd_a, fwd_b}, 8'd0);
`endif
    tick();
    eval();
    chk("dual_after_fwd", {4'd0, fwd_a, fwd_b}, 8'd0);
    chk("dual_after_issue", {7'd0, issue}, 8'd1);
    tick();
    step_idle(2);

    // Structural: second mul/div and an R0 writer while the unit is active.
    set_in(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1); eval(); tick();
    for (int k = 1; k <= 4; k++) begin
      set_in(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1); eval();
      chk($sformatf("st_md2_stall_t%0d", k), {7'd0, stall}, 8'd1);
      tick();
    end
    set_in(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1); eval();
    chk("st_md2_issue", {7'd0, issue}, 8'd1);
    tick();
    for (int k = 1; k <= 4; k++) begin
      set_in(1, 0, 4'd0, 0, 4'd0, 1, 4'd0, 0); eval();
      chk($sformatf("st_wr0_stall_t%0d", k), {7'd0, stall}, 8'd1);
      tick();
    end
    set_in(1, 0, 4'd0, 0, 4'd0, 1, 4'd0, 0); eval();
    chk("st_wr0_issue", {7'd0, issue}, 8'd1);
    tick();
    step_idle(1);
    for (int k = 1; k <= 2; k++) begin
      set_in(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1); eval();
      chk($sformatf("st_mdw0_stall_t%0d", k), {7'd0, stall}, 8'd1);
      tick();
    end
    set_in(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1); eval();
    chk("st_mdw0_issue", {7'd0, issue}, 8'd1);
    tick();
    step_idle(6);

    // Reset in the middle of a mul/div with valid slots.
    set_in(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1); eval(); tick();
    set_in(1, 0, 4'd0, 0, 4'd0, 1, 4'd9, 0); eval(); tick();
    set_in(1, 0, 4'd0, 0, 4'd0, 1, 4'd10, 0); eval(); tick();
    set_in(1, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0); eval();
    chk("rstm_pre_stall", {7'd0, stall}, 8'd1);
    chk("rstm_pre_busy", {7'd0, md_busy}, 8'd1);
    reset_now();
    eval();
    chk("rstm_busy", {7'd0, md_busy}, 8'd0);
    chk("rstm_wb_wr_en", {7'd0, wb_wr_en}, 8'd0);
    chk("rstm_stall", {7'd0, stall}, 8'd0);
    rst_n = 1'b1;
    tick();
    eval();
    chk("rstm_r0_issue", {7'd0, issue}, 8'd1);
    chk("rstm_md_start0", {7'd0, md_start}, 8'd0);
    tick();
    idle(); eval();
    chk("rstm_md_start1", {7'd0, md_start}, 8'd0);
    tick();

    // Randomized traffic; stalled instructions are usually held in ID.
    for (int n = 0; n < 600; n++) begin
      if (!(e_stall && $urandom_range(0, 3) != 0)) begin
        set_in(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 5)), 1'($urandom_range(0, 7) == 0));
      end
      eval();
      if ($urandom_range(0, 149) == 0) begin
        reset_now();
        eval();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and forwarding controller for the 16-bit four-stage core (ID, EX, MEM, WB). Tracks destination registers of in-flight instructions and the multi-cycle multiply/divide unit that writes R0. Drives the 2-bit forward selects of both register ports (00 = register file, 01 = WB write data, 10 = R0 result) and the ID stall. Also drives the register-file write enable and address.

## Interface
- REG_NUM_WIDTH, 4, register number width
- MD_LATENCY, 4, multiply/divide busy cycles before result (legal range 2..15)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- id_valid  input  1  ID holds a valid instruction
- id_rn_a, id_rn_b  input  4  source register numbers for ports A and B
- id_use_a, id_use_b  input  1  source A/B actually read
- id_wr_en  input  1  instruction writes id_rd through WB
- id_rd  input  4  destination register
- id_mdiv  input  1  mul/div instruction; result goes to R0 via unit; id_rd/id_wr_en ignored
- fwd_a, fwd_b  output  2  forward select for port A/B
- stall  output  1  hold ID; bubble into EX
- issue  output  1  id_valid & ~stall
- wb_wr_en  output  1  register-file write enable (WB slot)
- wb_rd  output  4  register-file write address
- md_start  output  1  one-cycle start pulse to mul/div unit
- md_busy  output  1  mul/div FSM not IDLE

## Operation
- Three slots EX, MEM, WB, each {valid, wr_en, rd}. Every cycle EX->MEM->WB shift. EX loads ID fields on issue, else invalid (bubble). Slots never hold.
- wb_wr_en = WB.valid & WB.wr_en; wb_rd = WB.rd. The register file writes at the end of that cycle.
- Per port, with use = id_valid & id_use_x, first match wins:
  - use=0 -> fwd=00, no hazard.
  - rn==0 & FSM DONE -> fwd=10.
  - rn==0 & FSM BUSY -> hazard.
  - rn matches valid writer in EX or MEM -> hazard.
  - rn matches valid writer in WB -> fwd=01.
  - otherwise fwd=00.
- Structural hazards, when id_valid:
  - id_mdiv with FSM not IDLE.
  - id_mdiv with any valid writer of R0 in EX/MEM/WB.
  - id_wr_en & id_rd==0 while FSM not IDLE.
- stall = any port hazard | any structural hazard. fwd_x is forced 00 when stall=1.
- Mul/div FSM:
  - IDLE -> BUSY on issue of id_mdiv, cnt=0.
  - BUSY: cnt+1 each cycle. At cnt==MD_LATENCY-1 -> DONE.
  - DONE: one cycle; unit presents R0 result on r0d and writes R0 at cycle end.
  - DONE -> IDLE.
  - md_start=1 only in the first BUSY cycle (registered). md_busy=1 in BUSY and DONE.
- Simultaneous events:
  - Port A and port B resolve independently. For example, A=10 while B=01 in the same cycle is legal.
  - A reader of R0 matching WB in DONE cannot occur, because writers of R0 are blocked while the FSM is active. If it did occur, 10 has priority.

## Timing
- Outputs fwd_a, fwd_b, stall and issue are combinational from ID inputs and state, valid in the same cycle.
- Instruction issued in cycle t: EX in t+1, MEM in t+2, WB in t+3 (wb_wr_en=1 in t+3). Visible through the register file from t+4.
- Mul/div issued in t: md_start in t+1; DONE in t+MD_LATENCY; R0 readable with fwd=10 in that cycle; IDLE at t+MD_LATENCY+1.
- Reset values: all slots invalid, FSM IDLE, cnt=0, wb_wr_en=0, wb_rd=0, md_start=0, md_busy=0, stall=0, fwd_a=fwd_b=00 (id_valid=0).
- Reset mid-operation discards slots and any mul/div in progress immediately. No md_start is produced after release until a new issue.

## Configuration
- HAZARD_FWD_WB_EN defined: WB-slot match gives fwd=01 with no stall.
- HAZARD_FWD_WB_EN undefined: WB-slot match is a hazard; one stall cycle, then fwd=00 from the register file. Select 01 is never driven.

## Test plan
- Back-to-back dependency: issue "wr R3" in t, reader of R3 on port A in t+1 -> stall=1 in t+1 and t+2; in t+3 fwd_a=01, issue=1. With macro undefined: stall through t+3, fwd_a=00 in t+4.
- Mul/div, MD_LATENCY=4: issue id_mdiv in t, reader of R0 on port B in t+1 -> md_start=1 in t+1; stall=1 t+1..t+3; t+4 fwd_b=10, issue=1; md_busy=0 in t+5.
- Structural: second id_mdiv and an "id_wr_en, id_rd=0" instruction in BUSY -> stall=1 until IDLE. id_mdiv with a writer of R0 in MEM -> stall 2 cycles.
- Dual port: A reads R5 (in WB), B reads R0 in DONE -> fwd_a=01, fwd_b=10, stall=0.
- No-use: id_use_a=0 with id_rn_a matching EX writer -> stall=0, fwd_a=00.
- Reset: assert rst_n=0 during BUSY (cnt=2) with valid slots -> md_busy=0, wb_wr_en=0, stall=0 asynchronously. After release, a reader of R0 issues without stall.
